button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 133 +++++++++++++
 tb/tb_button_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button debounce with press, release and long-press pulses
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_in_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_e;

    // Last count value of a qualification run; the accepting edge is the
    // one that samples the level again while the counter sits here.
    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Hold counter stops here so long_press can only fire once per press.
    localparam logic [CNT_W-1:0] HCNT_SAT  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] HCNT_FIRE = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_LOW;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // Next-state logic: qualify level changes and generate one-cycle pulses.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        unique case (state_q)
            S_LOW: begin
                if (sync_in_i) begin
                    state_d = S_RISE;
                    dcnt_d  = '0;
                end
            end

            S_RISE: begin
                if (!sync_in_i) begin
                    // Bounce during a rising qualification: start over.
                    state_d = S_LOW;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = S_HIGH;
                    dcnt_d  = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end

            S_HIGH: begin
                if (!sync_in_i) begin
                    state_d = S_FALL;
                    dcnt_d  = '0;
                end else if (hcnt_q < HCNT_SAT) begin
                    hcnt_d = hcnt_q + CNT_ONE;
                    if (hcnt_q == HCNT_FIRE) begin
                        long_d = 1'b1;
                    end
                end
            end

            S_FALL: begin
                if (sync_in_i) begin
                    // Short low glitch while held: resume holding, hold count frozen.
                    state_d = S_HIGH;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d   = S_LOW;
                    dcnt_d    = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_LOW;
                dcnt_d  = '0;
            end
        endcase
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed and random checks of button_debounce
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 8;

    logic clk_i;
    logic rst_ni;
    logic sync_in_i;
    logic level_o;
    logic press_o;
    logic release_o;
    logic long_press_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_press  = 0;
    int n_rel    = 0;
    int n_long   = 0;
    int press_cyc = 0;
    int long_cyc  = 0;

    // Reference model: accepted level, length of the current run of samples
    // that disagree with it, and count of undisturbed held-high samples.
    bit m_level;
    int m_run;
    int m_hold;
    bit m_press;
    bit m_rel;
    bit m_long;

    button_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sync_in_i   (sync_in_i),
        .level_o     (level_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .long_press_o(long_press_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0;
        m_run   = 0;
        m_hold  = 0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
    endtask

    // A level change is accepted after D+1 consecutive disagreeing samples.
    // Hold time counts held-high samples, skipping the sample that starts a
    // low glitch and the sample that ends it.
    task automatic model_step(input bit b);
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (b != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = b;
                m_run   = 0;
                if (b) begin
                    m_press = 1'b1;
                    m_hold  = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            if (m_level && m_run == 0 && m_hold < L) begin
                m_hold++;
                if (m_hold == L) m_long = 1'b1;
            end
            m_run = 0;
        end
    endtask

    // Called at a falling edge; drives one sample, checks after the rising edge.
    task automatic step(input bit b);
        sync_in_i = b;
        @(posedge clk_i);
        #1;
        cyc++;
        model_step(b);
        chk("level", level_o, m_level);
        chk("press", press_o, m_press);
        chk("release", release_o, m_rel);
        chk("long_press", long_press_o, m_long);
        if (press_o === 1'b1) begin n_press++; press_cyc = cyc; end
        if (release_o === 1'b1) n_rel++;
        if (long_press_o === 1'b1) begin n_long++; long_cyc = cyc; end
        @(negedge clk_i);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_level"}, level_o, 0);
        chk({tag, "_press"}, press_o, 0);
        chk({tag, "_release"}, release_o, 0);
        chk({tag, "_long"}, long_press_o, 0);
    endtask

    initial begin
        rst_ni    = 1'b0;
        sync_in_i = 1'b0;
        model_reset();
        #1;
        check_zero("reset_async");
        repeat (2) @(negedge clk_i);
        check_zero("reset_held");
        rst_ni = 1'b1;

        // Clean press
        for (int i = 0; i < D; i++) begin
            step(1'b1);
            chk("clean_press_early", press_o, 0);
        end
        step(1'b1);
        chk("clean_press_pulse", press_o, 1);
        chk("clean_press_level", level_o, 1);
        chk("clean_press_rel", release_o, 0);
        chk("clean_press_long", long_press_o, 0);

        // Long hold
        n_long = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            chk("hold_long", long_press_o, (i == L) ? 1 : 0);
            chk("hold_level", level_o, 1);
        end
        chk("hold_long_count", n_long, 1);
        chk("hold_long_offset", long_cyc - press_cyc, L);

        // Clean release
        for (int i = 0; i < D; i++) begin
            step(1'b0);
            chk("release_early_level", level_o, 1);
        end
        step(1'b0);
        chk("release_pulse", release_o, 1);
        chk("release_level", level_o, 0);
        step(1'b0);
        chk("release_one_cycle", release_o, 0);

        // Re-press needs a fresh hold for long_press
        for (int i = 0; i <= D; i++) step(1'b1);
        chk("repress_pulse", press_o, 1);
        for (int i = 1; i <= L; i++) begin
            step(1'b1);
            chk("repress_long", long_press_o, (i == L) ? 1 : 0);
        end

        // Release glitch
        begin
            bit pat [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
            n_rel = 0;
            for (int i = 0; i < 8; i++) begin
                step(pat[i]);
                chk("glitch_level", level_o, (i == 7) ? 0 : 1);
                chk("glitch_release", release_o, (i == 7) ? 1 : 0);
            end
            chk("glitch_release_count", n_rel, 1);
        end

        // Bounce on press
        begin
            bit pat [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
            n_press = 0;
            for (int i = 0; i < 8; i++) begin
                step(pat[i]);
                chk("bounce_press", press_o, (i == 7) ? 1 : 0);
            end
            chk("bounce_press_count", n_press, 1);
        end

        // Reset in the middle of a rising qualification
        for (int i = 0; i <= D; i++) step(1'b0);
        chk("pre_reset_level", level_o, 0);
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_ni = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        repeat (2) @(negedge clk_i);
        check_zero("midreset_held");
        rst_ni = 1'b1;
        for (int i = 0; i < D; i++) begin
            step(1'b1);
            chk("post_reset_early", press_o, 0);
        end
        step(1'b1);
        chk("post_reset_press", press_o, 1);

        // Random runs of bouncy input against the model
        for (int r = 0; r < 80; r++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 6);
            for (int k = 0; k < len; k++) step(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
